// File: rtl/timer_irq_sequencer.sv
// timer_irq_sequencer
//   Avalon-MM master for the 16-bit interval-timer slave. The sequence is:
//     1. Program the period.
//     2. Write control to start the counter.
//     3. Clear status on every timeout IRQ, emitting a one-cycle tick each time.
//     4. Optionally capture a 32-bit counter snapshot.
//
// Optional feature macro: TIMER_SEQ_SNAP_EN
//   When defined, the SNAP_* states, snap_req handling and snap_value/snap_valid
//   are present. When undefined, snap_req is ignored and the snapshot outputs
//   are tied to zero.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   cfg_start/cfg_stop  : pulse requests to program+start / stop the timer
//   cfg_period          : reload value (interval = cfg_period+1 clocks)
//   cfg_continuous      : 1 = periodic, 0 = one-shot
//   snap_req            : pulse request for a counter snapshot
//   busy/running        : state flags (busy = not IDLE, running = RUN/CLR/SNAP*)
//   tick, tick_count    : per-timeout pulse and wrapping count since cfg_start
//   snap_value/valid    : last snapshot and its one-cycle update strobe
//   av_*                : Avalon-MM master signals toward the timer slave
module timer_irq_sequencer #(
  parameter int TICK_CNT_W = 16,
  parameter bit CTRL_ITO   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_continuous,
  input  logic                  snap_req,
  output logic                  busy,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic [31:0]           snap_value,
  output logic                  snap_valid,
  output logic [3:0]            av_address,
  output logic                  av_chipselect,
  output logic                  av_write_n,
  output logic [15:0]           av_writedata,
  input  logic [15:0]           av_readdata,
  input  logic                  av_irq
);

`ifdef TIMER_SEQ_SNAP_EN
  typedef enum logic [3:0] {
    IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_CTRL, RUN, CLR, STOP,
    SNAP_WR, SNAP_RD0, SNAP_CAP0, SNAP_RD1, SNAP_CAP1
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, WR_P0, WR_P1, WR_P2, WR_P3, WR_CTRL, RUN, CLR, STOP
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [31:0]           period_q, period_d;
  logic                  cont_q, cont_d;
  logic [TICK_CNT_W-1:0] tick_count_q, tick_count_d;
  logic                  tick_q, tick_d;
  logic                  busy_q, busy_d;
  logic                  running_q, running_d;
  logic                  cs_q, cs_d;
  logic                  wn_q, wn_d;
  logic [3:0]            addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;

  wire start_accept = (state_q == IDLE) && cfg_start;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_start)     state_d = WR_P0;
        else if (cfg_stop) state_d = STOP;
      end
      WR_P0:   state_d = WR_P1;
      WR_P1:   state_d = WR_P2;
      WR_P2:   state_d = WR_P3;
      WR_P3:   state_d = WR_CTRL;
      WR_CTRL: state_d = RUN;
      RUN: begin
        if (av_irq)        state_d = CLR;
        else if (cfg_stop) state_d = STOP;
`ifdef TIMER_SEQ_SNAP_EN
        else if (snap_req) state_d = SNAP_WR;
`endif
      end
      CLR:       state_d = cont_q ? RUN : IDLE;
      STOP:      state_d = IDLE;
`ifdef TIMER_SEQ_SNAP_EN
      SNAP_WR:   state_d = SNAP_RD0;
      SNAP_RD0:  state_d = SNAP_CAP0;
      SNAP_CAP0: state_d = SNAP_RD1;
      SNAP_RD1:  state_d = SNAP_CAP1;
      SNAP_CAP1: state_d = RUN;
`endif
      default:   state_d = IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so that the bus
  // signals line up with the state they belong to. The period is taken
  // from its next value so WR_P0 already carries the freshly latched input.
  always_comb begin
    period_d     = start_accept ? cfg_period : period_q;
    cont_d       = start_accept ? cfg_continuous : cont_q;
    tick_d       = (state_d == CLR);
    tick_count_d = tick_count_q;
    if (start_accept)
      tick_count_d = '0;
    else if (state_d == CLR)
      tick_count_d = tick_count_q + TICK_CNT_W'(1);
    busy_d    = (state_d != IDLE);
    running_d = (state_d == RUN) || (state_d == CLR);
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    addr_d    = 4'd0;
    wdata_d   = 16'h0000;
    case (state_d)
      WR_P0:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd2; wdata_d = period_d[15:0];  end
      WR_P1:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd3; wdata_d = period_d[31:16]; end
      WR_P2:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd4; end
      WR_P3:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd5; end
      // Control: stop=0, start=1, cont, ito
      WR_CTRL: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1;
                     wdata_d = {12'b0, 1'b0, 1'b1, cont_d, CTRL_ITO}; end
      CLR:     begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd0; end
      STOP:    begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wdata_d = 16'h0008; end
`ifdef TIMER_SEQ_SNAP_EN
      SNAP_WR: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd6; running_d = 1'b1; end
      // Reads hold the address through the capture cycle.
      SNAP_RD0, SNAP_CAP0: begin cs_d = 1'b1; addr_d = 4'd6; running_d = 1'b1; end
      SNAP_RD1, SNAP_CAP1: begin cs_d = 1'b1; addr_d = 4'd7; running_d = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      tick_count_q <= '0;
      tick_q       <= 1'b0;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      tick_count_q <= tick_count_d;
      tick_q       <= tick_d;
      busy_q       <= busy_d;
      running_q    <= running_d;
      cs_q         <= cs_d;
      wn_q         <= wn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

`ifdef TIMER_SEQ_SNAP_EN
  logic [15:0] snap_lo_q;
  logic [31:0] snap_value_q;
  logic        snap_valid_q;

  // av_readdata is registered in the slave, so it is valid in the CAP cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= (state_q == SNAP_CAP1);
      if (state_q == SNAP_CAP0) snap_lo_q <= av_readdata;
      if (state_q == SNAP_CAP1) snap_value_q <= {av_readdata, snap_lo_q};
    end
  end

  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;
`else
  logic unused_snap_inputs;
  assign unused_snap_inputs = snap_req ^ (^av_readdata);
  assign snap_value = 32'h0;
  assign snap_valid = 1'b0;
`endif

  assign busy          = busy_q;
  assign running       = running_q;
  assign tick          = tick_q;
  assign tick_count    = tick_count_q;
  assign av_address    = addr_q;
  assign av_chipselect = cs_q;
  assign av_write_n    = wn_q;
  assign av_writedata  = wdata_q;

endmodule
